// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the SRAM controller: the access FSM state type
//   and the default timing/address-map parameters.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_DATA_BASE   = 1024;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Bridges a 32-bit MEM-stage load/store port onto a 16-bit asynchronous
//   SRAM. Each word access is split into a low half-word phase and a high
//   half-word phase, each WAIT_CYCLES long, followed by a one-cycle DONE in
//   which the pipeline is released.
//
// Parameters
//   WAIT_CYCLES  SRAM cycles per half-word phase (1..15)
//   DATA_BASE    byte address mapped to SRAM location 0
//
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   wr_en, rd_en store / load request, held stable while ready=0
//   address      word-aligned byte address
//   write_data   store data
//   read_data    registered load result, held until the next load
//   ready        combinational pipeline advance (low = freeze)
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_oe   drive enable for the SRAM data bus
//   sram_dq_in   SRAM read data
//   sram_we_n    SRAM write enable, active-low
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int DATA_BASE   = DEF_DATA_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       is_wr;

  // Half-word SRAM address: word index relative to DATA_BASE (mod 2^17)
  // with the half selector appended as the LSB.
  function automatic logic [17:0] half_addr(input logic [31:0] a, input logic hi);
    return 18'({32'((a - 32'(DATA_BASE)) >> 2), hi});
  endfunction

  // The pipeline is frozen while any request is outstanding, except in DONE.
  assign ready = !((wr_en || rd_en) && (state != DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      is_wr       <= 1'b0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            // Access type is frozen here; a simultaneous wr_en/rd_en is a write.
            state       <= LOW;
            cnt         <= 4'd0;
            is_wr       <= wr_en;
            sram_addr   <= half_addr(address, 1'b0);
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= !wr_en;
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            state       <= HIGH;
            cnt         <= 4'd0;
            if (!is_wr) read_data[15:0] <= sram_dq_in;
            sram_addr   <= half_addr(address, 1'b1);
            sram_dq_out <= write_data[31:16];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            state      <= DONE;
            cnt        <= 4'd0;
            if (!is_wr) read_data[31:16] <= sram_dq_in;
            // Release the bus; sram_addr keeps its last value.
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
//   Self-checking bench for sram_ctrl with a behavioural 16-bit SRAM and a
//   word-level reference memory.
module tb_sram_ctrl;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int LAT  = 1 + 2 * W;
  localparam int NWORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_ctrl #(.WAIT_CYCLES(W), .DATA_BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM.
  logic [15:0] dev [0:262143];
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) dev[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = dev[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Results of the most recent access.
  int          r_nlow, r_nwe, r_first_we, r_start, r_end;
  logic [17:0] r_alow, r_ahigh;
  logic        r_done;

  // Applies a request at posedge+1 and observes each cycle at the negedge
  // until ready rises (DONE). If flip_at>=0 the request is turned into a
  // store at that cycle to probe the latched access type.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input int flip_at);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    r_nlow = 0; r_nwe = 0; r_first_we = -1; r_done = 1'b0;
    r_alow = 'x; r_ahigh = 'x;
    r_start = cyc;
    for (int c = 0; c < 60 && !r_done; c++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        r_nwe++;
        if (r_first_we < 0) r_first_we = c;
      end
      if (c == 1) r_alow = sram_addr;
      if (c == 1 + W) r_ahigh = sram_addr;
      if (ready) begin
        r_done = 1'b1;
        r_end = cyc;
      end else begin
        r_nlow++;
        @(posedge clk); #1;
        if (c + 1 == flip_at) begin wr_en = 1'b1; rd_en = 1'b0; end
      end
    end
    check("access_completes", {31'd0, r_done}, 32'd1);
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  function automatic logic [31:0] word_addr(input int idx);
    return 32'(BASE + 4 * idx);
  endfunction

  function automatic logic [17:0] low_half(input int idx);
    return 18'(2 * idx);
  endfunction

  // Word-level reference model.
  logic [31:0] ref_mem [NWORDS];
  bit          ref_vld [NWORDS];
  logic [31:0] exp_rd;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    exp_rd = 32'd0;
    for (int i = 0; i < NWORDS; i++) ref_vld[i] = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      check("idle_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    end
    @(posedge clk); #1;

    // Write 0x12345678 at DATA_BASE.
    access(1'b1, 1'b0, 32'd1024, 32'h12345678, -1);
    check("w0_ready_low", r_nlow, LAT);
    check("w0_we_first", r_first_we, 1);
    check("w0_we_count", r_nwe, 2 * W);
    check("w0_sram0", {16'd0, dev[0]}, 32'h5678);
    check("w0_sram1", {16'd0, dev[1]}, 32'h1234);
    check("w0_rd_kept", read_data, 32'd0);
    release_req();
    ref_mem[0] = 32'h12345678; ref_vld[0] = 1'b1;

    // Read it back.
    access(1'b0, 1'b1, 32'd1024, 32'hdeadbeef, -1);
    check("r0_ready_low", r_nlow, LAT);
    check("r0_data", read_data, 32'h12345678);
    check("r0_we_count", r_nwe, 0);
    release_req();
    @(negedge clk);
    check("r0_ready_after", {31'd0, ready}, 32'd1);
    check("r0_data_held", read_data, 32'h12345678);
    @(posedge clk); #1;
    exp_rd = 32'h12345678;

    // Address map: 1032 -> word 2 -> half addresses 4/5.
    access(1'b1, 1'b0, 32'd1032, 32'hcafef00d, -1);
    check("w2_addr_low", {14'd0, r_alow}, 32'd4);
    check("w2_addr_high", {14'd0, r_ahigh}, 32'd5);
    check("w2_rd_kept", read_data, exp_rd);
    release_req();
    @(negedge clk);
    check("w2_addr_hold", {14'd0, sram_addr}, 32'd5);
    @(posedge clk); #1;
    ref_mem[2] = 32'hcafef00d; ref_vld[2] = 1'b1;

    // Back-to-back write then read with the request held throughout.
    begin
      int first_start;
      access(1'b1, 1'b0, word_addr(7), 32'ha5a55a5a, -1);
      first_start = r_start;
      @(posedge clk); #1;
      access(1'b0, 1'b1, word_addr(7), 32'h0, -1);
      check("b2b_second_low", r_nlow, LAT);
      check("b2b_total", r_end - first_start + 1, 12);
      check("b2b_data", read_data, 32'ha5a55a5a);
      release_req();
      ref_mem[7] = 32'ha5a55a5a; ref_vld[7] = 1'b1;
      exp_rd = 32'ha5a55a5a;
    end

    // wr_en and rd_en together: a write.
    access(1'b1, 1'b1, word_addr(9), 32'h0badc0de, -1);
    check("both_we_count", r_nwe, 2 * W);
    check("both_sram", {dev[low_half(9) + 18'd1], dev[low_half(9)]}, 32'h0badc0de);
    check("both_rd_kept", read_data, exp_rd);
    release_req();
    ref_mem[9] = 32'h0badc0de; ref_vld[9] = 1'b1;

    // Read whose inputs turn into a store mid-access: stays a read.
    access(1'b0, 1'b1, word_addr(2), 32'hffffffff, 2);
    check("flip_we_count", r_nwe, 0);
    check("flip_data", read_data, 32'hcafef00d);
    check("flip_ready_low", r_nlow, LAT);
    release_req();
    exp_rd = 32'hcafef00d;

    // Randomized accesses against the reference memory.
    for (int n = 0; n < 40; n++) begin
      int          idx;
      bit          wr;
      logic [31:0] d;
      idx = int'($urandom_range(NWORDS - 1, 0));
      wr  = ($urandom_range(1, 0) == 1) || !ref_vld[idx];
      d   = $urandom;
      access(wr, !wr, word_addr(idx), d, -1);
      check("rnd_ready_low", r_nlow, LAT);
      if (wr) begin
        ref_mem[idx] = d; ref_vld[idx] = 1'b1;
        check("rnd_w_sram", {dev[low_half(idx) + 18'd1], dev[low_half(idx)]}, ref_mem[idx]);
        check("rnd_w_we_count", r_nwe, 2 * W);
      end else begin
        exp_rd = ref_mem[idx];
        check("rnd_r_we_count", r_nwe, 0);
      end
      check("rnd_read_data", read_data, exp_rd);
      release_req();
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end

    // Reset asserted during the HIGH phase of a write.
    access(1'b0, 1'b1, 32'd1024, 32'h0, -1);
    check("pre_rst_data", read_data, 32'h12345678);
    release_req();
    @(posedge clk); #1;
    wr_en = 1'b1; address = word_addr(3); write_data = 32'h13572468;
    repeat (1 + W) @(posedge clk);
    #2;
    check("mid_high_we_n", {31'd0, sram_we_n}, 32'd0);
    check("mid_high_addr", {14'd0, sram_addr}, {14'd0, low_half(3) + 18'd1});
    rst = 1'b1;
    #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_read_data", read_data, 32'd0);
    check("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("abort_ready_req", {31'd0, ready}, 32'd0);
    wr_en = 1'b0;
    #1;
    check("abort_ready_idle", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check("post_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    @(posedge clk); #1;

    // Controller still works after the abort.
    access(1'b0, 1'b1, word_addr(9), 32'h0, -1);
    check("post_rst_ready_low", r_nlow, LAT);
    check("post_rst_read", read_data, 32'h0badc0de);
    release_req();
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the SRAM cycles per 16-bit half access (legal range 1..15).
REQ-002 Parameter DATA_BASE, default 1024, SHALL set the byte address mapped to SRAM location 0.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  MEM-stage store request, held stable while ready=0.
REQ-006 rd_en  in  1  MEM-stage load request, held stable while ready=0.
REQ-007 address  in  32  byte address from the ALU result; word-aligned.
REQ-008 write_data  in  32  store data (Rm value).
REQ-009 read_data  out  32  registered load result.
REQ-010 ready  out  1  high means the pipeline may advance; low means freeze.
REQ-011 sram_addr  out  18  SRAM half-word address.
REQ-012 sram_dq_out  out  16  SRAM write data.
REQ-013 sram_dq_oe  out  1  drive enable for the SRAM data bus.
REQ-014 sram_dq_in  in  16  SRAM read data.
REQ-015 sram_we_n  out  1  SRAM write enable, active-low.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOW, HIGH, DONE.
REQ-017 In IDLE with wr_en|rd_en=1, the FSM SHALL go to LOW with phase counter cnt=0; with no request it SHALL stay in IDLE.
REQ-018 In LOW/HIGH, cnt SHALL increment each cycle; at cnt==WAIT_CYCLES-1 the FSM SHALL go LOW->HIGH or HIGH->DONE and clear cnt.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 Address map: word index w=(address-DATA_BASE)>>2, modulo 2^17; in LOW, sram_addr={w[16:0],1'b0}; in HIGH, sram_addr={w[16:0],1'b1}.
REQ-021 Write: in LOW, sram_dq_out=write_data[15:0]; in HIGH, sram_dq_out=write_data[31:16]; sram_dq_oe=1 and sram_we_n=0 throughout both phases.
REQ-022 Read: sram_dq_oe=0 and sram_we_n=1; on the last LOW cycle sram_dq_in SHALL be captured into read_data[15:0]; on the last HIGH cycle into read_data[31:16].
REQ-023 read_data SHALL hold its value until the next read overwrites it; writes SHALL NOT change it.
REQ-024 ready = NOT((wr_en|rd_en) AND state!=DONE), combinational.
REQ-025 Latency: ready SHALL be low for 1+2*WAIT_CYCLES cycles and high in the DONE cycle (W=2: request in cycle 0, ready low in cycles 0-4, high in cycle 5).
REQ-026 When wr_en and rd_en are both high, the access SHALL be treated as a write.
REQ-027 The request type SHALL be latched on leaving IDLE; input changes mid-access SHALL NOT alter the access type.
REQ-028 A request present in the cycle after DONE (IDLE) SHALL start a new access; back-to-back accesses SHALL have no extra idle cycle beyond DONE->IDLE.
REQ-029 In IDLE and DONE: sram_we_n=1, sram_dq_oe=0, and sram_addr SHALL hold its last value.

Reset
REQ-030 While rst=1: state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
REQ-031 Reset mid-access SHALL abort the access immediately; the partial write is not completed and read_data is cleared to 0.
REQ-032 After reset release, ready SHALL follow REQ-024 with state=IDLE.

Structure
REQ-033 Package sram_ctrl_pkg SHALL hold the state enum type, the DATA_BASE default and the WAIT_CYCLES default.
REQ-034 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-035 Write 0x12345678 at address 1024 with W=2 -> SRAM[0]=0x5678, SRAM[1]=0x1234, ready low for 5 cycles, sram_we_n low in cycles 1-4.
REQ-036 Read at address 1024 after REQ-035 -> read_data=0x12345678 in cycle 5, ready high in cycle 5 only.
REQ-037 Write at address 1032 -> sram_addr=4 in LOW and 5 in HIGH.
REQ-038 Back-to-back write then read, request held continuously -> second access enters LOW one cycle after DONE, total 12 cycles, data correct.
REQ-039 Assert rst during HIGH of a write -> sram_we_n=1 and sram_dq_oe=0 immediately, state IDLE, read_data=0.
REQ-040 No request for 10 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0 throughout.
